// File: rtl/mem_access_unit.sv
// Memory stage: req/ack handshake with a variable-latency data memory, with a timeout.
// Stalls upstream while an access is outstanding and registers the writeback results.
module mem_access_unit #(
    parameter int unsigned WAIT_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    input  logic        mem_to_reg_in,
    input  logic        reg_to_mem_in,
    input  logic        reg_write_in,
    input  logic        ret_future_in,
    input  logic [3:0]  reg_rd_in,
    input  logic [15:0] alu_result,
    input  logic [15:0] sw_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic        wb_reg_write,
    output logic [3:0]  wb_reg_rd,
    output logic [15:0] wb_data,
    output logic        ret_wb,
    output logic        mem_err
);

    localparam logic [7:0] WaitLast = 8'(WAIT_MAX - 1);

    typedef enum logic [0:0] {
        StIdle,
        StAccess
    } state_e;

    state_e      r_state;
    state_e      w_state_next;
    logic [7:0]  r_wait_cnt;

    logic [15:0] r_pend_addr;
    logic [15:0] r_pend_wdata;
    logic        r_pend_we;
    logic        r_pend_load;
    logic        r_pend_reg_write;
    logic        r_pend_ret;
    logic [3:0]  r_pend_rd;

    logic        r_wb_valid;
    logic        r_wb_reg_write;
    logic [3:0]  r_wb_reg_rd;
    logic [15:0] r_wb_data;
    logic        r_ret_wb;
    logic        r_mem_err;

    logic        w_is_mem;
    logic        w_accept_alu;
    logic        w_accept_mem;
    logic        w_ack;
    logic        w_abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_is_mem     = mem_to_reg_in | reg_to_mem_in;
        w_accept_alu = 1'b0;
        w_accept_mem = 1'b0;
        w_ack        = 1'b0;
        w_abort      = 1'b0;
        case (r_state)
            StIdle: begin
                if (ex_valid) begin
                    if (w_is_mem) begin
                        w_accept_mem = 1'b1;
                        w_state_next = StAccess;
                    end else begin
                        w_accept_alu = 1'b1;
                    end
                end
            end
            StAccess: begin
                // An ack on the timeout edge takes priority over the abort.
                if (dmem_ack) begin
                    w_ack        = 1'b1;
                    w_state_next = StIdle;
                end else if (r_wait_cnt == WaitLast) begin
                    w_abort      = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt       <= '0;
            r_pend_addr      <= '0;
            r_pend_wdata     <= '0;
            r_pend_we        <= 1'b0;
            r_pend_load      <= 1'b0;
            r_pend_reg_write <= 1'b0;
            r_pend_ret       <= 1'b0;
            r_pend_rd        <= '0;
            r_wb_valid       <= 1'b0;
            r_wb_reg_write   <= 1'b0;
            r_wb_reg_rd      <= '0;
            r_wb_data        <= '0;
            r_ret_wb         <= 1'b0;
            r_mem_err        <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            if (w_accept_alu) begin
                r_wb_valid     <= 1'b1;
                r_wb_data      <= alu_result;
                r_wb_reg_rd    <= reg_rd_in;
                r_wb_reg_write <= reg_write_in;
                r_ret_wb       <= ret_future_in;
            end
            if (w_accept_mem) begin
                r_pend_addr      <= alu_result;
                r_pend_wdata     <= sw_data;
                r_pend_we        <= reg_to_mem_in;
                r_pend_load      <= mem_to_reg_in & ~reg_to_mem_in;
                r_pend_reg_write <= reg_write_in;
                r_pend_ret       <= ret_future_in;
                r_pend_rd        <= reg_rd_in;
                r_wait_cnt       <= '0;
            end
            if (r_state == StAccess && !w_ack && !w_abort) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
            if (w_ack) begin
                r_wb_valid  <= 1'b1;
                r_wb_reg_rd <= r_pend_rd;
                r_ret_wb    <= r_pend_ret;
                if (r_pend_load) begin
                    r_wb_data      <= dmem_rdata;
                    r_wb_reg_write <= r_pend_reg_write;
                end else begin
                    r_wb_data      <= r_pend_addr;
                    r_wb_reg_write <= 1'b0;
                end
            end
            if (w_abort) begin
                r_mem_err      <= 1'b1;
                r_wb_valid     <= 1'b1;
                r_wb_reg_write <= 1'b0;
                r_ret_wb       <= r_pend_ret;
            end
        end
    end

    assign dmem_req     = (r_state == StAccess);
    assign mem_stall    = (r_state == StAccess);
    assign dmem_we      = r_pend_we;
    assign dmem_addr    = r_pend_addr;
    assign dmem_wdata   = r_pend_wdata;
    assign wb_valid     = r_wb_valid;
    assign wb_reg_write = r_wb_reg_write;
    assign wb_reg_rd    = r_wb_reg_rd;
    assign wb_data      = r_wb_data;
    assign ret_wb       = r_ret_wb;
    assign mem_err      = r_mem_err;

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Memory stage of the pipeline, directly downstream of the execute stage. It takes the ALU result, store data and load/store/writeback controls produced by execute, and runs a req/ack handshake with a variable-latency data memory. It stalls upstream while an access is outstanding and presents registered writeback results, including the load data and the return flag, to the writeback stage.

## Interface
Parameters:
- WAIT_MAX, 8: maximum number of cycles `dmem_req` stays high before an access is aborted (legal range 2–255).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute stage presents a valid instruction this cycle.
- mem_to_reg_in  in  1  load: write memory data to the register file.
- reg_to_mem_in  in  1  store: write `sw_data` to memory.
- reg_write_in  in  1  instruction writes the register file.
- ret_future_in  in  1  instruction is a return; forwarded as `ret_wb`.
- reg_rd_in  in  4  destination register.
- alu_result  in  16  ALU result; this is the memory word address for load/store.
- sw_data  in  16  store data.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  16  word address.
- dmem_wdata  out  16  write data.
- dmem_rdata  in  16  read data; valid in the cycle `dmem_ack` is high.
- dmem_ack  in  1  access complete; one-cycle pulse.
- mem_stall  out  1  hold execute and earlier stages.
- wb_valid  out  1  writeback outputs valid this cycle.
- wb_reg_write  out  1  writeback enable.
- wb_reg_rd  out  4  writeback destination register.
- wb_data  out  16  writeback data: load data, or the ALU result for non-memory instructions.
- ret_wb  out  1  return reaches writeback.
- mem_err  out  1  sticky flag: an access has timed out.

## Operation
- FSM states: IDLE, ACCESS.
- Instruction classes:
  - Memory op: `mem_to_reg_in | reg_to_mem_in`.
  - If both are asserted, the instruction is treated as a store only; it performs no register writeback.
- IDLE, `ex_valid`=0: at the edge, `wb_valid`<=0.
- IDLE, `ex_valid`=1, non-memory op: at the edge, load the writeback registers:
  - `wb_valid`<=1, `wb_data`<=`alu_result`, `wb_reg_rd`<=`reg_rd_in`.
  - `wb_reg_write`<=`reg_write_in`, `ret_wb`<=`ret_future_in`.
  - Stay in IDLE.
- IDLE, `ex_valid`=1, memory op:
  - Latch address, wdata, we (`reg_to_mem_in`), reg_rd, reg_write, ret_future and the load flag into pending registers.
  - `wb_valid`<=0; wait counter <=0; go to ACCESS.
- ACCESS:
  - `dmem_req`=1; `dmem_addr`, `dmem_wdata` and `dmem_we` are driven from the pending registers and stay stable until the request completes.
  - `mem_stall`=1. Execute inputs are ignored; upstream holds them.
- ACCESS with `dmem_ack`=1 at an edge:
  - `wb_valid`<=1, `wb_reg_rd`<=pending rd, `ret_wb`<=pending ret.
  - Load: `wb_data`<=`dmem_rdata` and `wb_reg_write`<=pending reg_write.
  - Store: `wb_reg_write`<=0 and `wb_data`<=pending address.
  - Go to IDLE.
- ACCESS with `dmem_ack`=0:
  - Wait counter increments.
  - If the counter equals WAIT_MAX-1 at the edge: abort. `mem_err`<=1, `wb_valid`<=1, `wb_reg_write`<=0, `ret_wb`<=pending ret, go to IDLE.
- `dmem_ack` while `dmem_req`=0: ignored.
- `dmem_ack` that arrives after an abort: ignored.
- `mem_err` is cleared only by `rst`.
- `wb_*` registers hold their values when `wb_valid` is 0. Consumers qualify them with `wb_valid`.

## Timing
- Reset values, applied asynchronously: state IDLE, counter 0, `dmem_req`=0, `dmem_we`=0, `dmem_addr`=0, `dmem_wdata`=0, `mem_stall`=0, `wb_valid`=0, `wb_reg_write`=0, `wb_reg_rd`=0, `wb_data`=0, `ret_wb`=0, `mem_err`=0.
- Reset in ACCESS drops `dmem_req` immediately. The pending access is discarded and any later ack is ignored.
- Non-memory op: accepted at edge N; `wb_valid`=1 during cycle N+1. No stall.
- Memory op: accepted at edge N; `dmem_req` and `mem_stall` high from cycle N+1.
  - With ack sampled at edge M, `wb_valid`=1 and `mem_stall`=0 during cycle M+1.
  - Minimum latency (ack in cycle N+1): 2 cycles, with 1 stall cycle.
- `mem_stall` is the registered decode (state==ACCESS). The next instruction is accepted no earlier than edge M+1, so there is one bubble between back-to-back memory ops.
- Timeout: `dmem_req` is high for exactly WAIT_MAX cycles. `wb_valid` and `mem_err` rise in the following cycle.
- Ack in the same cycle as the timeout edge: ack wins and no error is raised.

## Test plan
- ALU pass-through: `ex_valid`=1, `alu_result`=0x1234, `reg_rd_in`=5, `reg_write_in`=1 -> next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_reg_rd`=5, `wb_reg_write`=1, `mem_stall`=0.
- Load with 3-cycle ack: LW to address 0x0040, ack in the 3rd `dmem_req` cycle with `dmem_rdata`=0xBEEF -> `mem_stall` high for 3 cycles, `dmem_we`=0, `dmem_addr`=0x0040 stable; then `wb_data`=0xBEEF, `wb_reg_write`=1.
- Store with immediate ack: SW to 0x0010 with `sw_data`=0xA5A5 -> `dmem_we`=1, `dmem_wdata`=0xA5A5 for 1 cycle; `wb_valid`=1 with `wb_reg_write`=0.
- Timeout, WAIT_MAX=8, no ack -> `dmem_req` high for exactly 8 cycles, then `mem_err`=1 (sticky), `wb_reg_write`=0. A late ack is ignored.
- Back-to-back LW, LW with a return flag on the second -> one bubble between them; second `wb_valid` cycle has `ret_wb`=1.
- Reset asserted mid-ACCESS -> `dmem_req`, `mem_stall` and `wb_valid` go to 0 without waiting for a clock edge. A subsequent ack produces no writeback.
